// File: rtl/pipe_stall_ctrl.sv
`default_nettype none
// ============================================================================
// pipe_stall_ctrl : merges stall requests into a per-stage stall vector, with
//                   flush window, consecutive-stall watchdog and perf counter.
// Revision: 1.0
// ============================================================================
module pipe_stall_ctrl #(
  parameter int                    STAGES       = 6,
  parameter int                    NREQ         = 2,
  parameter int                    IDX_W        = 3,
  parameter logic [NREQ*IDX_W-1:0] REQ_STAGE    = {3'd3, 3'd2},
  parameter int                    FLUSH_CYCLES = 2,
  parameter int                    TIMEOUT      = 1024,
  parameter int                    CNT_W        = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   stall_req_i,
  input  logic              flush_req_i,
  input  logic              clr_cnt_i,
  output logic [STAGES-1:0] stall_o,
  output logic              flush_o,
  output logic              flush_busy_o,
  output logic [CNT_W-1:0]  stall_cycles_o,
  output logic              stall_timeout_o
);

  localparam int                 FCNT_W    = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam int                 WCNT_W    = $clog2(TIMEOUT + 1);
  localparam logic [FCNT_W-1:0]  FCNT_LOAD = FCNT_W'(FLUSH_CYCLES - 1);
  localparam logic [WCNT_W-1:0]  WCNT_MAX  = WCNT_W'(TIMEOUT);
  localparam logic [WCNT_W-1:0]  WCNT_TRIP = WCNT_W'(TIMEOUT - 1);

  logic [IDX_W-1:0]  field [NREQ];
  logic              req_any;
  logic [IDX_W-1:0]  req_k;
  logic [STAGES-1:0] stall_raw;
  logic              stall_active;

  logic [FCNT_W-1:0] fcnt_q, fcnt_d;
  logic [WCNT_W-1:0] wcnt_q, wcnt_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              timeout_q, timeout_d;

  // Out-of-range stage indices are clamped to the last stage at elaboration.
  for (genvar gi = 0; gi < NREQ; gi++) begin : g_field
    localparam logic [IDX_W-1:0] RAW = REQ_STAGE[gi*IDX_W +: IDX_W];
    assign field[gi] = (int'(RAW) >= STAGES) ? IDX_W'(STAGES - 1) : RAW;
  end

  always_comb begin
    req_any = 1'b0;
    req_k   = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (stall_req_i[i]) begin
        req_any = 1'b1;
        if (field[i] > req_k) req_k = field[i];
      end
    end
    for (int j = 0; j < STAGES; j++) begin
      stall_raw[j] = req_any && (j <= int'(req_k));
    end
  end

  assign flush_busy_o    = (fcnt_q != '0);
  assign flush_o         = ~rst & (flush_req_i | flush_busy_o);
  assign stall_o         = (rst | flush_o) ? '0 : stall_raw;
  assign stall_active    = |stall_o;
  assign stall_cycles_o  = cnt_q;
  assign stall_timeout_o = timeout_q;

  always_comb begin
    fcnt_d    = fcnt_q;
    wcnt_d    = '0;
    cnt_d     = cnt_q;
    timeout_d = timeout_q;

    if (flush_req_i)          fcnt_d = FCNT_LOAD;
    else if (fcnt_q != '0)    fcnt_d = fcnt_q - FCNT_W'(1);

    if (stall_active) begin
      wcnt_d = (wcnt_q == WCNT_MAX) ? wcnt_q : wcnt_q + WCNT_W'(1);
      if (wcnt_q >= WCNT_TRIP) timeout_d = 1'b1;
      if (cnt_q != '1)         cnt_d     = cnt_q + CNT_W'(1);
    end

    // Clear takes priority over a same-edge increment or watchdog trip.
    if (clr_cnt_i) begin
      cnt_d     = '0;
      timeout_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fcnt_q    <= '0;
      wcnt_q    <= '0;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      fcnt_q    <= fcnt_d;
      wcnt_q    <= wcnt_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pipe_stall_ctrl.sv
`default_nettype none
// ============================================================================
// tb_pipe_stall_ctrl : directed stimulus, behavioural model + literal checks.
// Revision: 1.0
// ============================================================================
module tb_pipe_stall_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [1:0] req;
  logic       flush_req;
  logic       clr;

  logic [5:0]  stall_a, stall_b;
  logic        flush_a, busy_a, flush_b, busy_b;
  logic [2:0]  cyc_a;
  logic [31:0] cyc_b;
  logic        to_a, to_b;

  // A: short watchdog / narrow counter. B: long flush window, clamped stage field.
  pipe_stall_ctrl #(
    .STAGES(6), .NREQ(2), .IDX_W(3), .REQ_STAGE({3'd3, 3'd2}),
    .FLUSH_CYCLES(2), .TIMEOUT(4), .CNT_W(3)
  ) u_a (
    .clk(clk), .rst(rst), .stall_req_i(req), .flush_req_i(flush_req),
    .clr_cnt_i(clr), .stall_o(stall_a), .flush_o(flush_a),
    .flush_busy_o(busy_a), .stall_cycles_o(cyc_a), .stall_timeout_o(to_a)
  );

  pipe_stall_ctrl #(
    .STAGES(6), .NREQ(2), .IDX_W(3), .REQ_STAGE({3'd7, 3'd0}),
    .FLUSH_CYCLES(4), .TIMEOUT(1024), .CNT_W(32)
  ) u_b (
    .clk(clk), .rst(rst), .stall_req_i(req), .flush_req_i(flush_req),
    .clr_cnt_i(clr), .stall_o(stall_b), .flush_o(flush_b),
    .flush_busy_o(busy_b), .stall_cycles_o(cyc_b), .stall_timeout_o(to_b)
  );

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model configuration per instance
  localparam int FC [2] = '{2, 4};
  localparam int TO [2] = '{4, 1024};
  localparam int CW [2] = '{3, 32};
  localparam int RQ [2][2] = '{'{2, 3}, '{0, 7}};

  int     m_fc [2] = '{0, 0};
  int     m_w  [2] = '{0, 0};
  longint m_cnt[2] = '{0, 0};
  bit     m_to [2] = '{0, 0};
  int     n_fc [2] = '{0, 0};
  int     n_w  [2] = '{0, 0};
  longint n_cnt[2] = '{0, 0};
  bit     n_to [2] = '{0, 0};

  always @(negedge clk) begin
    if (chk_en) begin
      for (int n = 0; n < 2; n++) begin
        int          k;
        int          s;
        bit          e_flush;
        logic [5:0]  e_stall;
        longint      cmax;
        bit          st;
        string       pfx;
        pfx = (n == 0) ? "A." : "B.";
        e_flush = !rst && (flush_req || m_fc[n] > 0);
        k = -1;
        for (int i = 0; i < 2; i++) begin
          if (req[i]) begin
            s = (RQ[n][i] > 5) ? 5 : RQ[n][i];
            if (s > k) k = s;
          end
        end
        e_stall = (rst || e_flush || k < 0) ? 6'd0 : 6'((1 << (k + 1)) - 1);
        cmax = (64'd1 << CW[n]) - 1;

        chk({pfx, "flush"}, {63'd0, (n == 0) ? flush_a : flush_b}, {63'd0, e_flush});
        if (!rst)
          chk({pfx, "busy"}, {63'd0, (n == 0) ? busy_a : busy_b}, {63'd0, m_fc[n] > 0});
        chk({pfx, "stall"}, {58'd0, (n == 0) ? stall_a : stall_b}, {58'd0, e_stall});
        chk({pfx, "stall_cycles"}, (n == 0) ? {61'd0, cyc_a} : {32'd0, cyc_b}, m_cnt[n]);
        chk({pfx, "timeout"}, {63'd0, (n == 0) ? to_a : to_b}, {63'd0, m_to[n]});

        st = (e_stall != 0);
        if (rst) begin
          n_fc[n] = 0; n_w[n] = 0; n_cnt[n] = 0; n_to[n] = 1'b0;
        end else begin
          n_fc[n]  = flush_req ? FC[n] - 1 : ((m_fc[n] > 0) ? m_fc[n] - 1 : 0);
          n_w[n]   = st ? ((m_w[n] + 1 > TO[n]) ? TO[n] : m_w[n] + 1) : 0;
          n_to[n]  = clr ? 1'b0 : (m_to[n] || (st && m_w[n] + 1 >= TO[n]));
          n_cnt[n] = clr ? 0 : ((st && m_cnt[n] < cmax) ? m_cnt[n] + 1 : m_cnt[n]);
        end
      end
    end
  end

  always @(posedge clk) begin
    m_fc  <= n_fc;
    m_w   <= n_w;
    m_cnt <= n_cnt;
    m_to  <= n_to;
  end

  task automatic drv(input logic r, input logic [1:0] q, input logic f, input logic c);
    @(posedge clk);
    #1;
    rst = r; req = q; flush_req = f; clr = c;
    #2;
  endtask

  initial begin
    rst = 1'b1; req = 2'b11; flush_req = 1'b1; clr = 1'b0;
    #3;
    chk("rst.A.stall", {58'd0, stall_a}, 64'd0);
    chk("rst.A.flush", {63'd0, flush_a}, 64'd0);
    chk("rst.B.stall", {58'd0, stall_b}, 64'd0);
    chk("rst.B.flush", {63'd0, flush_b}, 64'd0);
    @(posedge clk);
    #1;
    chk_en = 1'b1;

    drv(1'b0, 2'b00, 1'b0, 1'b0);
    chk("rel.A.cycles", {61'd0, cyc_a}, 64'd0);
    chk("rel.A.timeout", {63'd0, to_a}, 64'd0);
    chk("rel.A.busy", {63'd0, busy_a}, 64'd0);

    // Priority decode
    drv(1'b0, 2'b01, 1'b0, 1'b0);
    chk("pri01.A", {58'd0, stall_a}, 64'b000111);
    chk("pri01.B", {58'd0, stall_b}, 64'b000001);
    drv(1'b0, 2'b10, 1'b0, 1'b0);
    chk("pri10.A", {58'd0, stall_a}, 64'b001111);
    chk("pri10.B.clamp", {58'd0, stall_b}, 64'b111111);
    drv(1'b0, 2'b11, 1'b0, 1'b0);
    chk("pri11.A", {58'd0, stall_a}, 64'b001111);
    drv(1'b0, 2'b00, 1'b0, 1'b0);
    chk("pri00.A", {58'd0, stall_a}, 64'd0);

    // Single flush window
    drv(1'b0, 2'b11, 1'b1, 1'b0);
    chk("fl0.flush", {63'd0, flush_a}, 64'd1);
    chk("fl0.busy", {63'd0, busy_a}, 64'd0);
    chk("fl0.stall", {58'd0, stall_a}, 64'd0);
    drv(1'b0, 2'b11, 1'b0, 1'b0);
    chk("fl1.flush", {63'd0, flush_a}, 64'd1);
    chk("fl1.busy", {63'd0, busy_a}, 64'd1);
    chk("fl1.stall", {58'd0, stall_a}, 64'd0);
    drv(1'b0, 2'b11, 1'b0, 1'b0);
    chk("fl2.flush", {63'd0, flush_a}, 64'd0);
    chk("fl2.stall", {58'd0, stall_a}, 64'b001111);
    repeat (3) drv(1'b0, 2'b00, 1'b0, 1'b0);

    // Restarted flush window
    drv(1'b0, 2'b11, 1'b1, 1'b0);
    drv(1'b0, 2'b11, 1'b1, 1'b0);
    chk("ext1.busy", {63'd0, busy_a}, 64'd1);
    drv(1'b0, 2'b11, 1'b0, 1'b0);
    chk("ext2.flush", {63'd0, flush_a}, 64'd1);
    chk("ext2.stall", {58'd0, stall_a}, 64'd0);
    drv(1'b0, 2'b11, 1'b0, 1'b0);
    chk("ext3.flush", {63'd0, flush_a}, 64'd0);
    chk("ext3.stall", {58'd0, stall_a}, 64'b001111);
    drv(1'b0, 2'b00, 1'b0, 1'b0);

    // Watchdog trip and stickiness
    drv(1'b0, 2'b00, 1'b0, 1'b1);
    repeat (3) drv(1'b0, 2'b01, 1'b0, 1'b0);
    drv(1'b0, 2'b01, 1'b0, 1'b0);
    chk("wd.3edges", {63'd0, to_a}, 64'd0);
    drv(1'b0, 2'b00, 1'b0, 1'b0);
    chk("wd.4edges", {63'd0, to_a}, 64'd1);
    drv(1'b0, 2'b00, 1'b0, 1'b0);
    chk("wd.sticky", {63'd0, to_a}, 64'd1);
    drv(1'b0, 2'b00, 1'b0, 1'b1);
    drv(1'b0, 2'b00, 1'b0, 1'b0);
    chk("wd.clr", {63'd0, to_a}, 64'd0);
    chk("wd.clr.cycles", {61'd0, cyc_a}, 64'd0);

    // Broken stall runs never trip
    repeat (3) drv(1'b0, 2'b01, 1'b0, 1'b0);
    drv(1'b0, 2'b00, 1'b0, 1'b0);
    repeat (3) drv(1'b0, 2'b01, 1'b0, 1'b0);
    drv(1'b0, 2'b00, 1'b0, 1'b0);
    chk("wd.gap", {63'd0, to_a}, 64'd0);

    // Counter saturation and clear-wins
    drv(1'b0, 2'b00, 1'b0, 1'b1);
    repeat (10) drv(1'b0, 2'b01, 1'b0, 1'b0);
    drv(1'b0, 2'b00, 1'b0, 1'b0);
    chk("cnt.sat", {61'd0, cyc_a}, 64'd7);
    chk("cnt.B", cyc_b, 64'd10);
    drv(1'b0, 2'b01, 1'b0, 1'b1);
    drv(1'b0, 2'b00, 1'b0, 1'b0);
    chk("cnt.clrwins", {61'd0, cyc_a}, 64'd0);
    chk("cnt.clr.timeout", {63'd0, to_a}, 64'd0);

    // Reset in the middle of a long flush window
    repeat (4) drv(1'b0, 2'b00, 1'b0, 1'b0);
    drv(1'b0, 2'b00, 1'b1, 1'b0);
    chk("rmf.B.flush0", {63'd0, flush_b}, 64'd1);
    drv(1'b1, 2'b11, 1'b0, 1'b0);
    chk("rmf.B.flush_rst", {63'd0, flush_b}, 64'd0);
    chk("rmf.B.stall_rst", {58'd0, stall_b}, 64'd0);
    drv(1'b0, 2'b00, 1'b0, 1'b0);
    chk("rmf.B.flush_rel", {63'd0, flush_b}, 64'd0);
    chk("rmf.B.busy_rel", {63'd0, busy_b}, 64'd0);
    drv(1'b0, 2'b10, 1'b0, 1'b0);
    chk("rmf.B.stall_after", {58'd0, stall_b}, 64'b111111);
    drv(1'b0, 2'b00, 1'b0, 1'b0);

    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pipe_stall_ctrl.md
Name: pipe_stall_ctrl

Overview:
Parametrised pipeline hazard controller, next generation of the CPU stall controller. It merges NREQ stall-request sources into a per-stage stall vector. Each source maps to a configurable stall depth; the deepest active source wins. It adds a multi-cycle flush window, a consecutive-stall watchdog and a saturating stall-cycle performance counter. It sits beside the pipeline and drives the stall and flush inputs of every stage register.

Parameters:
STAGES, 6, width of stall vector; bit 0 = PC stage, bit STAGES-1 = last stage
NREQ, 2, number of stall-request sources
IDX_W, 3, bits per stage index; 2**IDX_W >= STAGES
REQ_STAGE, {3'd3,3'd2}, packed NREQ*IDX_W vector; field i = deepest stage stalled by source i (default: source 0 = load-use -> 2, source 1 = execute -> 3)
FLUSH_CYCLES, 2, cycles the flush output is held per flush request (>=1)
TIMEOUT, 1024, consecutive stalled cycles that trip the watchdog (>=2)
CNT_W, 32, width of the stall-cycle counter

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  reset, synchronous, active-high
stall_req  in  NREQ  bit i = source i requests a stall this cycle (1 = Stop)
flush_req  in  1  exception/redirect flush request, one-cycle pulse or level
clr_cnt  in  1  synchronous clear of stall_cycles and stall_timeout
stall  out  STAGES  per-stage hold; bits [k:0] set when stalling through stage k
flush  out  1  pipeline flush, kill all in-flight stages
flush_busy  out  1  flush window active from a previous cycle's request
stall_cycles  out  CNT_W  count of cycles with stall != 0, saturating
stall_timeout  out  1  sticky watchdog flag

Behaviour:
- Stall decode, combinational, same cycle:
  - k = max REQ_STAGE[i] over all i with stall_req[i]=1.
  - stall = ones in bits [k:0], zeros above.
  - No request gives stall = 0.
  - REQ_STAGE fields >= STAGES are clamped to STAGES-1.
- Flush window:
  - Registered counter fcnt, range 0..FLUSH_CYCLES-1.
  - flush = flush_req | (fcnt != 0). flush_busy = (fcnt != 0).
  - flush_req=1 loads fcnt = FLUSH_CYCLES-1 next edge. This also restarts an active window.
  - Otherwise fcnt decrements while nonzero.
  - FLUSH_CYCLES=1 means flush follows flush_req only, and flush_busy stays 0.
- Flush priority: while flush=1, stall is forced to 0. Stall requests are ignored but not remembered.
- rst=1 combinationally forces stall=0 and flush=0. On the edge it clears fcnt, the watchdog counter, stall_cycles and stall_timeout.
- Reset during a flush window or a long stall aborts it; the next cycle starts clean.
- Watchdog:
  - wcnt increments on each cycle with stall != 0, saturating at TIMEOUT.
  - wcnt clears on any cycle with stall = 0.
  - When wcnt reaches TIMEOUT-1 and stall is still != 0, stall_timeout sets on that edge. It therefore reads 1 after exactly TIMEOUT consecutive stalled cycles.
  - stall_timeout is sticky until rst or clr_cnt.
- Perf counter: stall_cycles increments on each edge where stall != 0 (after flush masking). It saturates at all-ones and never wraps.
- clr_cnt on the same edge as a stalled cycle: clear wins, so the counter reads 0, not 1. Same rule for stall_timeout.
- clr_cnt does not affect fcnt, wcnt or stall.
- All registered outputs are 0 out of reset.

Test Plan:
- Reset, defaults: rst=1 with stall_req=2'b11, flush_req=1 -> stall=6'b000000, flush=0. Counters read 0 after release.
- Priority: stall_req=01 -> stall=000111; 10 -> 001111; 11 -> 001111; 00 -> 000000. Each is valid in the same cycle.
- Flush: with FLUSH_CYCLES=2, a one-cycle flush_req plus stall_req=11 held:
  - cycle 0 -> flush=1, busy=0, stall=0;
  - cycle 1 -> flush=1, busy=1, stall=0;
  - cycle 2 -> flush=0, stall=001111.
  - A second flush_req in cycle 1 extends the window through cycle 2.
- Watchdog: TIMEOUT=4, stall_req=01 held:
  - stall_timeout=0 after 3 edges, 1 after 4 edges.
  - It stays 1 after the request drops.
  - A 3-cycle stall, 1 idle cycle, then a 3-cycle stall never trips it.
- Counter: CNT_W=3 with 10 stalled cycles -> stall_cycles saturates at 7. clr_cnt asserted during a stalled cycle -> 0 next cycle.
- Reset mid-flush: FLUSH_CYCLES=4, flush_req, then rst on cycle 1 -> flush=0 during rst and after release, with no residual window.
